// File: rtl/bitrev_reorder.sv
// Ping-pong bit-reversal reorder buffer: frames of 2**LOG2N words in natural order out in bit-reversed order.
// Optional frame-length check enabled by defining BITREV_REORDER_FRAME_CHECK_EN (adds in_last_i / err_o).
module bitrev_reorder #(
  parameter int LOG2N = 3,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_dat_i,
  output logic         in_rdy_o,
  output logic         out_vld_o,
  output logic [W-1:0] out_dat_o,
  output logic         out_last_o,
  input  logic         out_rdy_i
`ifdef BITREV_REORDER_FRAME_CHECK_EN
  ,
  input  logic         in_last_i,
  output logic         err_o
`endif
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] IDX_MAX = LOG2N'(N - 1);

  logic [W-1:0]     mem [2][N];
  logic [1:0]       full, full_nxt;
  logic             wr_bank, rd_bank;
  logic [LOG2N-1:0] wr_idx, rd_idx;
  logic             wr_en, rd_en, wr_done, rd_done;

  function automatic logic [LOG2N-1:0] rev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  // Handshake decode uses registered flags only, so in_rdy_o never depends on out_rdy_i.
  assign in_rdy_o   = !full[wr_bank];
  assign out_vld_o  = full[rd_bank];
  assign wr_en      = in_vld_i && in_rdy_o;
  assign rd_en      = out_vld_o && out_rdy_i;
  assign wr_done    = wr_en && (wr_idx == IDX_MAX);
  assign rd_done    = rd_en && (rd_idx == IDX_MAX);
  assign out_dat_o  = out_vld_o ? mem[rd_bank][rev(rd_idx)] : '0;
  assign out_last_o = out_vld_o && (rd_idx == IDX_MAX);

  // Write completion and read completion always target different banks.
  always_comb begin
    full_nxt = full;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      rd_idx  <= '0;
    end else begin
      full <= full_nxt;
      if (wr_en) wr_idx <= wr_idx + LOG2N'(1);
      if (wr_done) wr_bank <= !wr_bank;
      if (rd_en) rd_idx <= rd_idx + LOG2N'(1);
      if (rd_done) rd_bank <= !rd_bank;
    end
  end

  // Frame storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_idx] <= in_dat_i;
  end

`ifdef BITREV_REORDER_FRAME_CHECK_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      err_o <= 1'b0;
    end else if (wr_en && (in_last_i != (wr_idx == IDX_MAX))) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bitrev_reorder.sv
// Self-checking bench for bitrev_reorder: directed and random streams against a frame-level queue model.
module tb_bitrev_reorder;
  localparam int LOG2N = 3;
  localparam int W     = 16;
  localparam int N     = 1 << LOG2N;

  logic         clk = 1'b0;
  logic         arst_n;
  logic         in_vld, in_rdy, out_vld, out_last, out_rdy;
  logic [W-1:0] in_dat, out_dat;
  logic         vld_b, in_rdy_b, out_vld_b, out_last_b, rdy_b;
  logic [W-1:0] dat_b, out_dat_b;
`ifdef BITREV_REORDER_FRAME_CHECK_EN
  logic in_last, err, last_b, err_b;
`endif

  always #5 clk = ~clk;

  bitrev_reorder #(.LOG2N(LOG2N), .W(W)) dut (
    .clk(clk), .arst_n(arst_n),
    .in_vld_i(in_vld), .in_dat_i(in_dat), .in_rdy_o(in_rdy),
    .out_vld_o(out_vld), .out_dat_o(out_dat), .out_last_o(out_last), .out_rdy_i(out_rdy)
`ifdef BITREV_REORDER_FRAME_CHECK_EN
    , .in_last_i(in_last), .err_o(err)
`endif
  );

  bitrev_reorder #(.LOG2N(1), .W(W)) dut_b (
    .clk(clk), .arst_n(arst_n),
    .in_vld_i(vld_b), .in_dat_i(dat_b), .in_rdy_o(in_rdy_b),
    .out_vld_o(out_vld_b), .out_dat_o(out_dat_b), .out_last_o(out_last_b), .out_rdy_i(rdy_b)
`ifdef BITREV_REORDER_FRAME_CHECK_EN
    , .in_last_i(last_b), .err_o(err_b)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of whole frames already permuted, plus the partial frame being collected.
  logic [W-1:0] part[$];
  logic [W-1:0] frm[$];
  int           ridx = 0;
  logic         err_m = 1'b0;
  logic         last_acc;
  int           force_last_at = -1;

  logic [W-1:0] bw [4];
  int           bwi = 0;
  int           bout = 0;
  logic         b_run = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rev_sw(input int k, input int lg);
    int r = 0;
    for (int b = 0; b < lg; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  function automatic void model_reset();
    part.delete();
    frm.delete();
    ridx  = 0;
    err_m = 1'b0;
  endfunction

  task automatic step();
    int           nfull;
    logic         e_rdy, e_vld, e_last, acc, xfer, bacc;
    logic [W-1:0] e_dat;
    nfull  = frm.size() / N;
    e_rdy  = (nfull < 2);
    e_vld  = (nfull > 0);
    e_dat  = e_vld ? frm[ridx] : '0;
    e_last = e_vld && (ridx == N - 1);
    vld_b  = b_run && (bwi < 4);
    dat_b  = bw[bwi[1:0]];
`ifdef BITREV_REORDER_FRAME_CHECK_EN
    in_last = (force_last_at >= 0) ? (part.size() == force_last_at) : (part.size() == N - 1);
    last_b  = bwi[0];
`endif
    #1;
    chk("in_rdy", 32'(in_rdy), 32'(e_rdy));
    chk("out_vld", 32'(out_vld), 32'(e_vld));
    chk("out_dat", 32'(out_dat), 32'(e_dat));
    chk("out_last", 32'(out_last), 32'(e_last));
`ifdef BITREV_REORDER_FRAME_CHECK_EN
    chk("err", 32'(err), 32'(err_m));
`endif
    if (out_vld_b && rdy_b) begin
      chk("b_dat", 32'(out_dat_b), 32'(bw[bout[1:0]]));
      chk("b_last", 32'(out_last_b), 32'(bout[0]));
      bout++;
    end
    acc  = in_vld && e_rdy;
    xfer = e_vld && out_rdy;
    bacc = vld_b && in_rdy_b;
    last_acc = acc;
    @(posedge clk);
    if (xfer) begin
      if (ridx == N - 1) begin
        repeat (N) void'(frm.pop_front());
        ridx = 0;
      end else begin
        ridx++;
      end
    end
    if (acc) begin
`ifdef BITREV_REORDER_FRAME_CHECK_EN
      if (in_last != (part.size() == N - 1)) err_m = 1'b1;
`endif
      part.push_back(in_dat);
      if (part.size() == N) begin
        for (int k = 0; k < N; k++) frm.push_back(part[rev_sw(k, LOG2N)]);
        part.delete();
      end
    end
    if (bacc) bwi++;
    @(negedge clk);
  endtask

  // Offer words first..last-1 in order; each word is held until it is accepted.
  task automatic stream(input int first, input int last, input logic rdy);
    int w = first;
    int budget = 0;
    while (w < last && budget < 200) begin
      in_vld  = 1'b1;
      in_dat  = W'(w);
      out_rdy = rdy;
      step();
      if (last_acc) w++;
      budget++;
    end
    in_vld = 1'b0;
    chk("stream_budget", 32'(w), 32'(last));
  endtask

  task automatic drain();
    int budget = 0;
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    while (frm.size() != 0 && budget < 100) begin
      step();
      budget++;
    end
    chk("drain_budget", 32'(frm.size()), 32'(0));
  endtask

  initial begin
    bw[0] = 16'd5; bw[1] = 16'd9; bw[2] = 16'd5; bw[3] = 16'd9;
    arst_n  = 1'b0;
    in_vld  = 1'b0;
    in_dat  = '0;
    out_rdy = 1'b0;
    vld_b   = 1'b0;
    dat_b   = '0;
    rdy_b   = 1'b1;
`ifdef BITREV_REORDER_FRAME_CHECK_EN
    in_last = 1'b0;
    last_b  = 1'b0;
`endif
    @(negedge clk);
    #1;
    chk("rst_out_vld", 32'(out_vld), 32'(0));
    chk("rst_out_dat", 32'(out_dat), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    chk("rst_in_rdy", 32'(in_rdy), 32'(1));
    @(negedge clk);
    arst_n = 1'b1;

    // Single frame 0..7 with the N=2 instance running its 5,9,5,9 stream alongside.
    b_run = 1'b1;
    stream(0, 8, 1'b1);
    drain();
    repeat (4) step();
    chk("b_word_count", 32'(bout), 32'(4));
    b_run = 1'b0;

    // Back-to-back frames at full rate.
    stream(0, 32, 1'b1);
    drain();

    // Backpressure: fill both banks, hold, then release.
    stream(0, 16, 1'b0);
    in_vld = 1'b1;
    in_dat = W'(16);
    out_rdy = 1'b0;
    repeat (5) step();
    stream(16, 24, 1'b1);
    drain();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      in_vld  = ($urandom_range(3) != 0);
      in_dat  = W'($urandom);
      out_rdy = ($urandom_range(2) != 0);
      step();
    end
    drain();
    while (part.size() != 0) stream(0, 1, 1'b1);
    drain();

    // Reset in the middle of a frame discards it.
    stream(0, 5, 1'b1);
    arst_n = 1'b0;
    #2;
    chk("mid_rst_out_vld", 32'(out_vld), 32'(0));
    chk("mid_rst_in_rdy", 32'(in_rdy), 32'(1));
    model_reset();
    @(negedge clk);
    arst_n = 1'b1;
    step();
    stream(100, 108, 1'b1);
    drain();

`ifdef BITREV_REORDER_FRAME_CHECK_EN
    force_last_at = 5;
    stream(200, 208, 1'b1);
    force_last_at = -1;
    drain();
    chk("err_sticky", 32'(err), 32'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
